// File: rtl/perf_rolling_collector.sv
// Multi-channel rolling perf collector: accumulates per-channel y sums against
// a shared x counter, snapshots on window close and drains one record per channel.
module perf_rolling_collector #(
   parameter int          NCH      = 4,
   parameter int          INC_W    = 8,
   parameter logic [63:0] X_WINDOW = 64'd1000,
   parameter int          DROP_W   = 32,
   localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic [NCH*INC_W-1:0]   y_inc,
   input  logic [INC_W-1:0]       x_inc,
   input  logic [63:0]            stamp,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CH_W-1:0]        out_chan,
   output logic [63:0]            out_yAxisPt,
   output logic [63:0]            out_xAxisPt,
   output logic [63:0]            out_stamp,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   busy
);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t          state, state_nxt;
   logic [CH_W-1:0] chan, chan_nxt;
   logic [63:0]     x_acc, x_sum;
   logic [63:0]     y_acc  [NCH];
   logic [63:0]     y_sum  [NCH];
   logic [63:0]     snap_y [NCH];
   logic [63:0]     snap_x, snap_stamp;
   logic            close, hs, last, load, drop;

   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [INC_W-1:0] b);
      logic [64:0] s;
      s = {1'b0, a} + 65'(b);
      return s[64] ? '1 : s[63:0];
   endfunction

   always_comb begin
      x_sum = sat_add(x_acc, x_inc);
      for (int i = 0; i < NCH; i++)
         y_sum[i] = sat_add(y_acc[i], y_inc[i*INC_W +: INC_W]);
   end

   // A close may only load when nothing is pending or the last record leaves now.
   assign close = en && (x_sum >= X_WINDOW);
   assign hs    = (state == DRAIN) && out_ready;
   assign last  = (chan == CH_W'(NCH - 1));
   assign load  = close && ((state == IDLE) || (hs && last));
   assign drop  = close && !load;

   always_comb begin
      state_nxt = state;
      chan_nxt  = chan;
      unique case (state)
         IDLE: begin
            if (load) begin
               state_nxt = DRAIN;
               chan_nxt  = '0;
            end
         end
         DRAIN: begin
            if (hs) begin
               if (!last) begin
                  chan_nxt = chan + CH_W'(1);
               end else begin
                  chan_nxt  = '0;
                  state_nxt = load ? DRAIN : IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            chan_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         chan       <= '0;
         x_acc      <= '0;
         snap_x     <= '0;
         snap_stamp <= '0;
         drop_cnt   <= '0;
         for (int i = 0; i < NCH; i++) begin
            y_acc[i]  <= '0;
            snap_y[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         chan  <= chan_nxt;
         if (en) begin
            x_acc <= close ? '0 : x_sum;
            for (int i = 0; i < NCH; i++)
               y_acc[i] <= close ? '0 : y_sum[i];
         end
         if (load) begin
            snap_x     <= x_sum;
            snap_stamp <= stamp;
            for (int i = 0; i < NCH; i++)
               snap_y[i] <= y_sum[i];
         end
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + DROP_W'(1);
      end
   end

   assign out_valid   = (state == DRAIN);
   assign busy        = (state == DRAIN);
   assign out_chan    = chan;
   assign out_xAxisPt = snap_x;
   assign out_stamp   = snap_stamp;

   generate
      if (NCH == 1) begin : g_one
         assign out_yAxisPt = snap_y[0];
      end else begin : g_many
         assign out_yAxisPt = snap_y[chan];
      end
   endgenerate

endmodule
